// File: rtl/tcp_rt_timer_engine.sv
// tcp_rt_timer_engine: per-flow retransmission timer engine.
// TX path arms/disarms a deadline per flow; a scanner walks all flows against a
// prescaled free-running time base and, on expiry, issues an rt_pend SET update
// to the TCP scheduler.
//
// Optional feature macro: RT_TIMER_STATS_EN
//   adds stat_expiry_cnt / stat_suppressed_cnt saturating counters.
//
// rt_sched_update_cmd is the flat sched_cmd_struct image:
//   [FLOWID_W+5:6] flowid
//   [5:4]          rt_pend_set_clear   (NOP = 2'd0, SET = 2'd1, CLEAR = 2'd2)
//   [3:2]          ack_pend_set_clear
//   [1:0]          data_pend_set_clear
module tcp_rt_timer_engine #(
   parameter int NUM_FLOWS = 16,
   parameter int FLOWID_W  = $clog2(NUM_FLOWS),
   parameter int TIME_W    = 16,
   parameter int TICK_DIV  = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                timer_cmd_val,
   input  logic                timer_cmd_arm,
   input  logic [FLOWID_W-1:0] timer_cmd_flowid,
   input  logic [TIME_W-1:0]   timer_cmd_timeout,
   output logic                timer_cmd_rdy,
   output logic                rt_sched_update_val,
   output logic [FLOWID_W+5:0] rt_sched_update_cmd,
   input  logic                sched_rt_update_rdy,
   output logic [TIME_W-1:0]   now_time
`ifdef RT_TIMER_STATS_EN
   ,
   output logic [31:0]         stat_expiry_cnt,
   output logic [31:0]         stat_suppressed_cnt
`endif
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
   localparam logic [1:0] PEND_NOP = 2'd0;
   localparam logic [1:0] PEND_SET = 2'd1;

   typedef enum logic [1:0] {
      SCAN_RD  = 2'd0,
      SCAN_CHK = 2'd1,
      EMIT     = 2'd2
   } scan_state_t;

   scan_state_t         state;
   logic [PRESC_W-1:0]  presc;
   logic [FLOWID_W-1:0] idx;
   logic [NUM_FLOWS-1:0] armed;
   logic [TIME_W-1:0]   deadline_mem [NUM_FLOWS];

   logic                armed_p0;
   logic [TIME_W-1:0]   deadline_p0;
   logic [FLOWID_W-1:0] flowid_p0;

   logic                cmd_acc;
   logic [TIME_W-1:0]   arm_deadline;
   logic                rd_fwd;
   logic                due_p1;
   logic                cmd_hit_p1;
   logic                expire_p1;

   // Wrap-safe "deadline reached": the signed age now - deadline is non-negative.
   function automatic logic is_due(input logic [TIME_W-1:0] now_t,
                                   input logic [TIME_W-1:0] dl);
      logic signed [TIME_W-1:0] age;
      age = signed'(now_t - dl);
      return ~age[TIME_W-1];
   endfunction

   assign cmd_acc      = timer_cmd_val & timer_cmd_rdy;
   assign arm_deadline = now_time + timer_cmd_timeout;

   // A command landing on the entry being read is forwarded into the latch so the
   // check stage never works on a pre-command copy of that flow.
   assign rd_fwd = cmd_acc & (timer_cmd_flowid == idx);

   // ---- stage p0 -> p1: expiry decision on the latched entry ----
   assign due_p1     = armed_p0 & is_due(now_time, deadline_p0);
   assign cmd_hit_p1 = (state == SCAN_CHK) & cmd_acc & (timer_cmd_flowid == flowid_p0);
   assign expire_p1  = (state == SCAN_CHK) & due_p1 & ~cmd_hit_p1;

   // Command interface is ready one cycle after reset release and stays ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timer_cmd_rdy <= 1'b0;
      else        timer_cmd_rdy <= 1'b1;
   end

   // Prescaler and time base; now_time advances once per TICK_DIV cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         now_time <= '0;
      end else if (presc == PRESC_MAX) begin
         presc    <= '0;
         now_time <= now_time + 1'b1;
      end else begin
         presc    <= presc + 1'b1;
      end
   end

   // Armed bits: scanner clears on expiry, a same-cycle command to the flow wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed <= '0;
      end else begin
         if (expire_p1) armed[flowid_p0] <= 1'b0;
         if (cmd_acc)   armed[timer_cmd_flowid] <= timer_cmd_arm;
      end
   end

   // Deadline storage, written on every accepted arm (not reset).
   always_ff @(posedge clk) begin
      if (cmd_acc && timer_cmd_arm) deadline_mem[timer_cmd_flowid] <= arm_deadline;
   end

   // ---- stage p0: latch entry[idx] while the scanner is in SCAN_RD ----
   always_ff @(posedge clk) begin
      if (state == SCAN_RD) begin
         flowid_p0 <= idx;
         if (rd_fwd) begin
            armed_p0    <= timer_cmd_arm;
            deadline_p0 <= timer_cmd_arm ? arm_deadline : deadline_mem[idx];
         end else begin
            armed_p0    <= armed[idx];
            deadline_p0 <= deadline_mem[idx];
         end
      end
   end

   // Scanner FSM: read, check, and hold the expiry command until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= SCAN_RD;
         idx                 <= '0;
         rt_sched_update_val <= 1'b0;
      end else begin
         unique case (state)
            SCAN_RD: begin
               state <= SCAN_CHK;
            end
            SCAN_CHK: begin
               if (expire_p1) begin
                  rt_sched_update_val <= 1'b1;
                  state               <= EMIT;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= SCAN_RD;
               end
            end
            EMIT: begin
               if (sched_rt_update_rdy) begin
                  rt_sched_update_val <= 1'b0;
                  idx                 <= idx + 1'b1;
                  state               <= SCAN_RD;
               end
            end
            default: begin
               rt_sched_update_val <= 1'b0;
               state               <= SCAN_RD;
            end
         endcase
      end
   end

   // flowid_p0 only changes in SCAN_RD, so the command is stable through EMIT.
   assign rt_sched_update_cmd = {flowid_p0, PEND_SET, PEND_NOP, PEND_NOP};

`ifdef RT_TIMER_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   // Saturating counters: completed expiries and expiries suppressed by a command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_expiry_cnt     <= '0;
         stat_suppressed_cnt <= '0;
      end else begin
         if (rt_sched_update_val && sched_rt_update_rdy)
            stat_expiry_cnt <= sat_inc(stat_expiry_cnt);
         if (cmd_hit_p1 && due_p1)
            stat_suppressed_cnt <= sat_inc(stat_suppressed_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_tcp_rt_timer_engine.sv
// Testbench for tcp_rt_timer_engine (NUM_FLOWS=16, TIME_W=8, TICK_DIV=4).
module tb_tcp_rt_timer_engine;

   localparam int NF = 16;
   localparam int FW = 4;
   localparam int TW = 8;
   localparam int TD = 4;
   localparam logic [1:0] P_NOP = 2'd0;
   localparam logic [1:0] P_SET = 2'd1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_val = 1'b0;
   logic          cmd_arm = 1'b0;
   logic [FW-1:0] cmd_flow = '0;
   logic [TW-1:0] cmd_to = '0;
   logic          cmd_rdy;
   logic          up_val;
   logic [FW+5:0] up_cmd;
   logic          up_rdy = 1'b1;
   logic [TW-1:0] now_time;
`ifdef RT_TIMER_STATS_EN
   logic [31:0]   st_exp;
   logic [31:0]   st_sup;
`endif

   always #5 clk = ~clk;

   tcp_rt_timer_engine #(
      .NUM_FLOWS(NF), .FLOWID_W(FW), .TIME_W(TW), .TICK_DIV(TD)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .timer_cmd_val       (cmd_val),
      .timer_cmd_arm       (cmd_arm),
      .timer_cmd_flowid    (cmd_flow),
      .timer_cmd_timeout   (cmd_to),
      .timer_cmd_rdy       (cmd_rdy),
      .rt_sched_update_val (up_val),
      .rt_sched_update_cmd (up_cmd),
      .sched_rt_update_rdy (up_rdy),
      .now_time            (now_time)
`ifdef RT_TIMER_STATS_EN
      ,
      .stat_expiry_cnt     (st_exp),
      .stat_suppressed_cnt (st_sup)
`endif
   );

   int checks = 0;
   int failures = 0;
   int cyc;

   typedef struct {
      logic [FW-1:0] flow;
      logic [TW-1:0] t;
   } emit_t;

   // Reference model: per-flow armed/deadline, time derived from cycle count.
   bit            m_armed [NF];
   logic [TW-1:0] m_dl [NF];
   emit_t         emit_q [$];
   bit            p_val;
   bit            p_rdy;
   logic [FW+5:0] p_cmd;
   logic [TW-1:0] p_now;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin : monitor
      logic [TW-1:0] mnow;
      logic [TW-1:0] age;
      logic [FW-1:0] f;
      emit_t         e;
      if (!rst_n) begin
         for (int i = 0; i < NF; i++) m_armed[i] = 1'b0;
         p_val = 1'b0;
         p_rdy = 1'b0;
      end else begin
         mnow = TW'(cyc / TD);
         check("now_time", 32'(now_time), 32'(mnow));
         check("cmd_rdy", 32'(cmd_rdy), 32'(cyc > 0));
         if (up_val) begin
            if (p_val && !p_rdy) begin
               check("cmd_stable", 32'(up_cmd), 32'(p_cmd));
            end else begin
               f   = up_cmd[FW+5:6];
               age = p_now - m_dl[f];
               check("cmd_pend_fields", 32'(up_cmd[5:0]), 32'({P_SET, P_NOP, P_NOP}));
               check("emit_is_due", 32'(m_armed[f] && (age < 8'd128)), 32'd1);
               m_armed[f] = 1'b0;
               e.flow = f;
               e.t    = p_now;
               emit_q.push_back(e);
            end
         end
         if (cmd_val && cmd_rdy) begin
            m_armed[cmd_flow] = cmd_arm;
            if (cmd_arm) m_dl[cmd_flow] = mnow + cmd_to;
         end
         p_val = up_val;
         p_rdy = up_rdy;
         p_cmd = up_cmd;
         p_now = mnow;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cmd_val = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("rst_val", 32'(up_val), 32'd0);
      check("rst_rdy", 32'(cmd_rdy), 32'd0);
      check("rst_now", 32'(now_time), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      emit_q.delete();
   endtask

   task automatic do_cmd(input logic arm, input logic [FW-1:0] f, input logic [TW-1:0] to);
      cmd_val  = 1'b1;
      cmd_arm  = arm;
      cmd_flow = f;
      cmd_to   = to;
      tick();
      cmd_val  = 1'b0;
   endtask

   task automatic wait_now(input logic [TW-1:0] target);
      for (int k = 0; k < 1200 && now_time != target; k++) tick();
      check("wait_now_reached", 32'(now_time), 32'(target));
   endtask

   task automatic get_emit(output emit_t e, output bit ok, input int max_ticks);
      ok = 1'b0;
      e.flow = '0;
      e.t = '0;
      for (int k = 0; k < max_ticks && emit_q.size() == 0; k++) tick();
      check("emit_arrived", 32'(emit_q.size() != 0), 32'd1);
      if (emit_q.size() != 0) begin
         e  = emit_q.pop_front();
         ok = 1'b1;
      end
   endtask

   typedef struct {
      logic [TW-1:0] arm_now;
      logic [FW-1:0] flow;
      logic [TW-1:0] timeout;
      logic [TW-1:0] exp_dl;
   } vec_t;

   vec_t vecs [5];

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin : main
      emit_t         e;
      bit            ok;
      logic [TW-1:0] lag;
      logic [TW-1:0] mnow;
      logic [FW-1:0] order [3];

      vecs[0] = '{8'd3,   4'd5,  8'd10,  8'd13};
      vecs[1] = '{8'd250, 4'd7,  8'd10,  8'd4};
      vecs[2] = '{8'd20,  4'd0,  8'd0,   8'd20};
      vecs[3] = '{8'd40,  4'd15, 8'd127, 8'd167};
      vecs[4] = '{8'd60,  4'd11, 8'd1,   8'd61};

      // Reset and idle time base
      up_rdy = 1'b1;
      do_reset();
      repeat (100) tick();
      check("idle_now", 32'(now_time), 32'd25);
      check("idle_rdy", 32'(cmd_rdy), 32'd1);
      check("idle_val", 32'(up_val), 32'd0);

      // Single-flow arm vectors, including deadline wrap
      for (int i = 0; i < 5; i++) begin
         do_reset();
         wait_now(vecs[i].arm_now);
         do_cmd(1'b1, vecs[i].flow, vecs[i].timeout);
         get_emit(e, ok, 800);
         if (ok) begin
            lag = e.t - vecs[i].exp_dl;
            check("vec_flow", 32'(e.flow), 32'(vecs[i].flow));
            check("vec_not_early", 32'(lag < 8'd128), 32'd1);
            check("vec_in_window", 32'(lag <= 8'd10), 32'd1);
         end
         repeat (400) tick();
         check("vec_no_repeat", 32'(emit_q.size()), 32'd0);
      end

      // Disarm before deadline
      do_reset();
      tick();
      do_cmd(1'b1, 4'd2, 8'd5);
      wait_now(8'd4);
      do_cmd(1'b0, 4'd2, 8'd0);
      repeat (200) tick();
      check("disarm_no_emit", 32'(emit_q.size()), 32'd0);

      // Back-pressure with three expired flows
      up_rdy = 1'b0;
      do_reset();
      tick();
      do_cmd(1'b1, 4'd1, 8'd0);
      do_cmd(1'b1, 4'd3, 8'd0);
      do_cmd(1'b1, 4'd9, 8'd0);
      repeat (50) tick();
      check("stall_val", 32'(up_val), 32'd1);
      check("stall_flow", 32'(up_cmd[FW+5:6]), 32'd1);
      up_rdy = 1'b1;
      order[0] = 4'd1;
      order[1] = 4'd3;
      order[2] = 4'd9;
      for (int i = 0; i < 3; i++) begin
         get_emit(e, ok, 200);
         if (ok) check("stall_order", 32'(e.flow), 32'(order[i]));
      end
      repeat (100) tick();
      check("stall_no_extra", 32'(emit_q.size()), 32'd0);

      // Reset during EMIT drops the pending command
      up_rdy = 1'b0;
      do_reset();
      tick();
      do_cmd(1'b1, 4'd1, 8'd0);
      repeat (10) tick();
      check("pre_rst_val", 32'(up_val), 32'd1);
      do_reset();
      up_rdy = 1'b1;
      repeat (100) tick();
      check("rst_no_replay", 32'(emit_q.size()), 32'd0);

      // Re-arm collides with SCAN_CHK of an expired flow
      up_rdy = 1'b1;
      do_reset();
      tick();
      do_cmd(1'b1, 4'd4, 8'd0);
      repeat (7) tick();
      do_cmd(1'b1, 4'd4, 8'd20);
      get_emit(e, ok, 300);
      if (ok) begin
         lag = e.t - 8'd22;
         check("collide_flow", 32'(e.flow), 32'd4);
         check("collide_not_early", 32'(lag < 8'd128), 32'd1);
         check("collide_in_window", 32'(lag <= 8'd10), 32'd1);
      end
`ifdef RT_TIMER_STATS_EN
      check("stat_suppressed", st_sup, 32'd1);
      check("stat_expiry", st_exp, 32'd1);
`endif

      // Randomized traffic against the reference model
      up_rdy = 1'b1;
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         cmd_val  = ($urandom_range(0, 2) == 0);
         cmd_arm  = ($urandom_range(0, 3) != 0);
         cmd_flow = FW'($urandom_range(0, NF - 1));
         cmd_to   = TW'($urandom_range(0, 40));
         up_rdy   = ($urandom_range(0, 3) != 0);
         tick();
      end
      cmd_val = 1'b0;
      up_rdy  = 1'b1;
      repeat (300) tick();
      mnow = TW'(cyc / TD);
      for (int f = 0; f < NF; f++) begin
         lag = mnow - m_dl[f];
         check("rand_no_missed", 32'(m_armed[f] && (lag >= 8'd16) && (lag < 8'd128)), 32'd0);
      end
      emit_q.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tcp_rt_timer_engine.md
Name: tcp_rt_timer_engine

Overview:
Per-flow retransmission-timer engine that sits directly upstream of the round-robin TCP scheduler.
- The TX path arms or disarms a deadline per flow.
- A scanner walks all flows against a free-running time base.
- On expiry it issues a scheduler update command that sets the flow's rt_pend flag.
- Its output feeds one of the scheduler's sched_cmd_struct val/rdy update ports.

Parameters:
NUM_FLOWS, 16 (MAX_TCP_FLOWS), number of flows tracked; power of two.
FLOWID_W, $clog2(NUM_FLOWS), flow id width.
TIME_W, 16, width of the time base and of stored deadlines.
TICK_DIV, 256, clk cycles per time tick; must be >= 1.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
timer_cmd_val  in  1  timer command valid.
timer_cmd_arm  in  1  1 = arm/re-arm, 0 = disarm.
timer_cmd_flowid  in  FLOWID_W  target flow.
timer_cmd_timeout  in  TIME_W  timeout in ticks; must be < 2^(TIME_W-1).
timer_cmd_rdy  out  1  always 1 out of reset.
rt_sched_update_val  out  1  expiry command valid.
rt_sched_update_cmd  out  sched_cmd_struct  flowid = expired flow; rt_pend_set_clear = SET; ack_pend_set_clear and data_pend_set_clear = NOP (tcp_misc_pkg encodings).
sched_rt_update_rdy  in  1  scheduler accepts command.
now_time  out  TIME_W  current time base.

Behaviour:
Reset and interface:
- One clock (clk); reset rst_n is asynchronous, active-low.
- While rst_n = 0: all armed bits = 0, now_time = 0, prescaler = 0, scan index = 0, FSM = SCAN_RD, rt_sched_update_val = 0, timer_cmd_rdy = 0.
- Deadline storage is not reset.
- A reset asserted mid-EMIT drops the pending command; it is not replayed.

Time base:
- The prescaler counts 0..TICK_DIV-1.
- At TICK_DIV-1 it returns to 0 and now_time increments by 1, wrapping modulo 2^TIME_W.
- With TICK_DIV = 1, now_time increments every cycle.

Per-flow state:
- Each flow holds {armed, deadline[TIME_W-1:0]} in flops.

Commands:
- A command is accepted on val & rdy and written at the clock edge.
- Arm: armed = 1, deadline = now_time + timeout, truncated to TIME_W.
- Disarm: armed = 0.
- Re-arming an armed flow overwrites its deadline.

Expiry test:
- expired = armed & ((now_time - deadline) mod 2^TIME_W < 2^(TIME_W-1)), which is wrap-safe.
- timeout = 0 expires on the next visit.

Scanner FSM:
- SCAN_RD: latch entry[idx] and idx into pipeline regs; go to SCAN_CHK.
- SCAN_CHK:
  - If a command accepted this cycle targets the latched flowid, the command wins; no expiry; idx++; go to SCAN_RD.
  - Else if the latched entry is expired: clear its armed bit; go to EMIT.
  - Else: idx++; go to SCAN_RD.
- EMIT:
  - rt_sched_update_val = 1, cmd held stable until sched_rt_update_rdy.
  - On handshake: idx++; go to SCAN_RD.
  - Commands accepted during EMIT (including a re-arm of the emitting flow) are stored normally; emission still completes.
- idx wraps from NUM_FLOWS-1 to 0.
- Each flow emits at most once per arm.

Latency:
- Idle scan period is 2*NUM_FLOWS cycles.
- Expiry is emitted at most 2*NUM_FLOWS cycles plus downstream stall after now_time reaches the deadline.

Optional Feature:
RT_TIMER_STATS_EN.
- When defined, adds output stat_expiry_cnt [31:0].
- The counter increments on every EMIT handshake, saturates at 0xFFFFFFFF, and is reset to 0 by rst_n.
- Adds output stat_suppressed_cnt [31:0], counting SCAN_CHK command-wins collisions on an expired entry, with the same saturation and reset rules.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset, then idle 100 cycles (TICK_DIV=4) -> rt_sched_update_val = 0, timer_cmd_rdy = 1, now_time = 25.
2. Arm flow 5 with timeout 10 at now_time = 3, rdy held 1 -> exactly one command {flowid=5, rt=SET, ack=NOP, data=NOP} within 32 cycles after now_time reaches 13; none before now_time = 13; none afterwards.
3. Arm flow 2 with timeout 5, then disarm at now_time = 4 -> no command ever for flow 2.
4. TIME_W=8; arm flow 7 at now_time = 250 with timeout 10 (deadline 4 after wrap) -> no expiry at now_time 250..255 or 0..3; expiry emitted once now_time >= 4.
5. Arm flows 1, 3, 9 with timeout 0 and hold sched_rt_update_rdy = 0 for 50 cycles -> val is held with flowid 1 and cmd stable; on release, commands appear in order 1, 3, 9, one per handshake.
6. Flow 4 expired; drive an arm of flow 4 (timeout 20) in the same cycle the scanner is in SCAN_CHK on flow 4 -> no command for flow 4; new deadline honoured 20 ticks later (stat_suppressed_cnt = 1 when RT_TIMER_STATS_EN is defined).
